// File: rtl/apb_seq_master.sv
// ---------------------------------------------------------------------------
// apb_seq_master
//
// Queues read/write commands in a small FIFO and replays them, strictly in
// order and one at a time, as APB transfers. Each transfer produces exactly
// one response. If the completer holds pready low for TMO ACCESS cycles, the
// transfer is aborted and reported as an error plus timeout.
//
// Parameters
//   AW     APB address width
//   DW     APB data width
//   DEPTH  command FIFO depth (power of 2, >= 2)
//   TMO    ACCESS cycles allowed before abort (>= 2)
//
// Ports
//   clk, reset_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command push handshake
//   cmd_write/cmd_addr/cmd_wdata       command payload (cmd_write=1 -> write)
//   rsp_valid/rsp_ready                response handshake
//   rsp_rdata/rsp_err/rsp_tmo          response payload
//   psel/penable/pwrite/paddr/pwdata   APB requester outputs
//   prdata/pready/pslverr              APB completer inputs
//   busy                               sequencer is not idle
//   level                              FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module apb_seq_master #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int TMO   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [AW-1:0]            cmd_addr,
  input  logic [DW-1:0]            cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DW-1:0]            rsp_rdata,
  output logic                     rsp_err,
  output logic                     rsp_tmo,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [AW-1:0]            paddr,
  output logic [DW-1:0]            pwdata,
  input  logic [DW-1:0]            prdata,
  input  logic                     pready,
  input  logic                     pslverr,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(TMO) + 1;
  localparam int EW = 1 + AW + DW;
  localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TMO - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  // -------------------------------------------------------------------------
  // Command FIFO
  // -------------------------------------------------------------------------
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [LW-1:0] count_reg;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          head_write;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_wdata;

  state_t        state_reg;

  assign full  = (count_reg == FULL_LVL);
  assign empty = (count_reg == '0);
  // Fullness is judged before any same-edge pop, so a full FIFO never
  // accepts a push even while an entry is leaving.
  assign push  = cmd_valid && !full;
  // Pop from IDLE, or right at the response handshake so the next transfer
  // starts its SETUP on the very next edge.
  assign pop   = !empty && ((state_reg == IDLE) ||
                            ((state_reg == RESP) && rsp_ready));

  // The head entry feeds the registered APB outputs directly, so the read
  // is effectively registered at the APB side.
  assign {head_write, head_addr, head_wdata} = mem[rd_ptr_reg];

  // Storage array has no reset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + LW'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - LW'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Transfer sequencer
  // -------------------------------------------------------------------------
  logic          psel_reg;
  logic          penable_reg;
  logic          pwrite_reg;
  logic [AW-1:0] paddr_reg;
  logic [DW-1:0] pwdata_reg;
  logic          rsp_valid_reg;
  logic [DW-1:0] rsp_rdata_reg;
  logic          rsp_err_reg;
  logic          rsp_tmo_reg;
  logic [TW-1:0] wait_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      psel_reg      <= 1'b0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
      rsp_tmo_reg   <= 1'b0;
      wait_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Leaving IDLE is handled by the common pop branch below.
        end
        SETUP: begin
          penable_reg <= 1'b1;
          wait_reg    <= '0;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_rdata_reg <= pwrite_reg ? '0 : prdata;
            rsp_err_reg   <= pslverr;
            rsp_tmo_reg   <= 1'b0;
            rsp_valid_reg <= 1'b1;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            state_reg     <= RESP;
          end else if (wait_reg == WAIT_LAST) begin
            // This was the TMO-th ACCESS cycle without pready: abort.
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b1;
            rsp_tmo_reg   <= 1'b1;
            rsp_valid_reg <= 1'b1;
            psel_reg      <= 1'b0;
            penable_reg   <= 1'b0;
            state_reg     <= RESP;
          end else begin
            wait_reg <= wait_reg + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase

      // Starting a transfer from IDLE or straight out of a response
      // handshake; overrides the IDLE target chosen in RESP above.
      if (pop) begin
        paddr_reg   <= head_addr;
        pwrite_reg  <= head_write;
        pwdata_reg  <= head_wdata;
        psel_reg    <= 1'b1;
        penable_reg <= 1'b0;
        state_reg   <= SETUP;
      end
    end
  end

  assign cmd_ready = !full;
  assign level     = count_reg;
  assign busy      = (state_reg != IDLE);
  assign psel      = psel_reg;
  assign penable   = penable_reg;
  assign pwrite    = pwrite_reg;
  assign paddr     = paddr_reg;
  assign pwdata    = pwdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_tmo   = rsp_tmo_reg;

endmodule

// File: doc/apb_seq_master.md
APB_SEQ_MASTER -- requirements
Module: apb_seq_master

Interface
REQ-001 The block SHALL have parameter AW, default 32, APB address width.
REQ-002 The block SHALL have parameter DW, default 32, APB data width.
REQ-003 The block SHALL have parameter DEPTH, default 4, command FIFO depth in entries, a power of 2 and at least 2.
REQ-004 The block SHALL have parameter TMO, default 16, maximum ACCESS cycles before abort, at least 2.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 cmd_valid  in  1, cmd_ready  out  1  command push handshake.
REQ-008 cmd_write  in  1, cmd_addr  in  AW, cmd_wdata  in  DW  command payload (1 = write).
REQ-009 rsp_valid  out  1, rsp_ready  in  1  response handshake.
REQ-010 rsp_rdata  out  DW, rsp_err  out  1, rsp_tmo  out  1  response payload.
REQ-011 psel, penable, pwrite  out  1 each; paddr  out  AW; pwdata  out  DW  APB requester outputs.
REQ-012 prdata  in  DW, pready  in  1, pslverr  in  1  APB completer inputs.
REQ-013 busy  out  1  (FSM not IDLE); level  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-014 cmd_ready SHALL equal !full; a push SHALL occur on any edge with cmd_valid && cmd_ready.
REQ-015 FIFO SHALL be first-in first-out; pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-016 Simultaneous push and pop SHALL leave level unchanged; when full, a push SHALL NOT occur even if a pop happens the same edge.
REQ-017 FSM states SHALL be IDLE, SETUP, ACCESS, RESP.
REQ-018 IDLE: if FIFO non-empty, pop the head entry and go to SETUP next edge; else stay.
REQ-019 SETUP: psel=1, penable=0, paddr/pwrite/pwdata from popped entry; unconditionally go to ACCESS.
REQ-020 ACCESS: psel=1, penable=1; paddr, pwrite, pwdata SHALL stay stable for the whole ACCESS phase.
REQ-021 ACCESS with pready=1: capture rsp_rdata = prdata for reads, 0 for writes; capture rsp_err = pslverr, rsp_tmo = 0; go to RESP.
REQ-022 ACCESS with pready=0: increment wait counter; after TMO ACCESS cycles without pready, abort: go to RESP with rsp_err=1, rsp_tmo=1, rsp_rdata=0.
REQ-023 RESP: psel=0, penable=0, rsp_valid=1; payload SHALL hold stable until rsp_valid && rsp_ready.
REQ-024 On response handshake, if FIFO non-empty, pop and go directly to SETUP; else go to IDLE.
REQ-025 No new APB transfer SHALL start while a response is pending (strict in-order, one outstanding).
REQ-026 Latency: command pushed into empty FIFO on edge N with pready=1 -> psel high after N+1, penable after N+2, rsp_valid after N+3.
REQ-027 paddr, pwrite, pwdata SHALL hold last driven values when psel=0; psel and penable SHALL NOT be high outside SETUP/ACCESS.
REQ-028 pready and pslverr SHALL be ignored outside ACCESS.

Reset
REQ-029 reset_n low SHALL asynchronously force: FSM IDLE, FIFO empty (level=0), cmd_ready=1, psel=penable=pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=rsp_tmo=0, busy=0, wait counter 0.
REQ-030 Reset during an APB transfer SHALL drop psel/penable immediately, discard in-flight and queued commands, and produce no response.

Verification
REQ-031 Push write addr 0x0000_0000 data 0x6041_C0C0, pready=1 -> psel rises one cycle after push, penable the next, rsp_valid next with rsp_err=0, rsp_rdata=0.
REQ-032 Read addr 0x10, pready low 3 ACCESS cycles, prdata=0xDEAD_BEEF -> ACCESS lasts 4 cycles, paddr stable, rsp_rdata=0xDEAD_BEEF.
REQ-033 Push 5 commands with DEPTH=4, no consumption -> cmd_ready low after 4th, level=4, 5th accepted only after a pop.
REQ-034 pready held 0, TMO=16 -> abort after 16 ACCESS cycles, psel=0, rsp_err=1, rsp_tmo=1.
REQ-035 rsp_ready held 0 for 5 cycles with 2 queued commands -> no SETUP until handshake, then SETUP on the following edge.
REQ-036 reset_n asserted mid-ACCESS with 3 queued -> psel=0 same cycle, level=0, no rsp_valid after release.
